// File: rtl/lc3_mem_ctrl.sv
// lc3_mem_ctrl
//   Memory and memory-mapped I/O controller for the LC-3 datapath. Holds MAR
//   and MDR, runs each access through IDLE -> WAIT -> DONE with a configurable
//   number of wait states, and decodes the keyboard/display device registers.
//
// Parameters
//   WIDTH        data / Bus width (>= 16)
//   ADDR_W       MAR width (>= 16)
//   DEPTH_LOG2   backing RAM holds 2^DEPTH_LOG2 words starting at address 0
//   WAIT_STATES  extra cycles spent in WAIT per access (0..15)
//
// Ports
//   clk, reset          single clock, synchronous active-low reset
//   Bus                 shared datapath bus (MAR / MDR source)
//   ldMAR, ldMDR        register load strobes
//   selMDR              MDR source: 0 = Bus, 1 = completed read data
//   mem_en, memWE       start an access at MAR, write when memWE is set
//   R                   one-cycle access-complete pulse
//   MDROut              MDR contents
//   addr_err            one-cycle pulse with R when the address is unmapped
//   kb_data, kb_valid   keyboard character and strobe
//   dd_data, dd_valid   display character and pending flag
//   dd_ready            display accepts the pending character
module lc3_mem_ctrl #(
  parameter int WIDTH       = 16,
  parameter int ADDR_W      = 16,
  parameter int DEPTH_LOG2  = 10,
  parameter int WAIT_STATES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] Bus,
  input  logic             ldMAR,
  input  logic             ldMDR,
  input  logic             selMDR,
  input  logic             mem_en,
  input  logic             memWE,
  output logic             R,
  output logic [WIDTH-1:0] MDROut,
  output logic             addr_err,
  input  logic [7:0]       kb_data,
  input  logic             kb_valid,
  output logic [7:0]       dd_data,
  output logic             dd_valid,
  input  logic             dd_ready
);

  localparam int CNT_W = 4;
  localparam int DEPTH = 1 << DEPTH_LOG2;

  localparam logic [ADDR_W-1:0] KBSR_ADDR = ADDR_W'(16'hFE00);
  localparam logic [ADDR_W-1:0] KBDR_ADDR = ADDR_W'(16'hFE02);
  localparam logic [ADDR_W-1:0] DSR_ADDR  = ADDR_W'(16'hFE04);
  localparam logic [ADDR_W-1:0] DDR_ADDR  = ADDR_W'(16'hFE06);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DONE
  } state_t;

  state_t state, next_state;
  logic [CNT_W-1:0] wait_cnt, next_cnt;

  logic [ADDR_W-1:0] mar;
  logic [WIDTH-1:0]  mdr;
  logic [WIDTH-1:0]  rd_data;

  // Address and direction of the access in flight, captured when it starts so
  // that ldMAR during WAIT/DONE only affects the following access.
  logic [ADDR_W-1:0] acc_addr;
  logic              acc_we;

  logic [7:0] kb_char;
  logic       kb_ready;
  logic       kb_overrun;

  logic [WIDTH-1:0] ram [0:DEPTH-1];

  logic                  is_kbsr, is_kbdr, is_dsr, is_ddr, is_dev;
  logic                  ram_hit, mapped;
  logic                  done, done_read, done_write;
  logic [DEPTH_LOG2-1:0] ram_idx;
  logic [WIDTH-1:0]      rd_value;

  // State register
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= ST_IDLE;
      wait_cnt <= '0;
    end else begin
      state    <= next_state;
      wait_cnt <= next_cnt;
    end
  end

  // Next-state logic; the WAIT counter is preloaded with WAIT_STATES-1 so
  // that WAIT lasts exactly WAIT_STATES cycles.
  always_comb begin
    next_state = state;
    next_cnt   = wait_cnt;
    unique case (state)
      ST_IDLE: begin
        if (mem_en) begin
          if (WAIT_STATES == 0) begin
            next_state = ST_DONE;
          end else begin
            next_state = ST_WAIT;
            next_cnt   = CNT_W'(WAIT_STATES - 1);
          end
        end
      end
      ST_WAIT: begin
        if (wait_cnt == '0) begin
          next_state = ST_DONE;
        end else begin
          next_cnt = wait_cnt - CNT_W'(1);
        end
      end
      ST_DONE: begin
        next_state = ST_IDLE;
      end
      default: begin
        next_state = ST_IDLE;
      end
    endcase
  end

  // Address decode and read mux for the access in flight. Device registers
  // take precedence in case the RAM is configured large enough to overlap.
  always_comb begin
    is_kbsr    = (acc_addr == KBSR_ADDR);
    is_kbdr    = (acc_addr == KBDR_ADDR);
    is_dsr     = (acc_addr == DSR_ADDR);
    is_ddr     = (acc_addr == DDR_ADDR);
    is_dev     = is_kbsr || is_kbdr || is_dsr || is_ddr;
    ram_hit    = !is_dev && ((acc_addr >> DEPTH_LOG2) == '0);
    mapped     = ram_hit || is_dev;
    ram_idx    = acc_addr[DEPTH_LOG2-1:0];
    done       = (state == ST_DONE);
    done_read  = done && !acc_we;
    done_write = done && acc_we;

    rd_value = '0;
    if (ram_hit) begin
      rd_value = ram[ram_idx];
    end else if (is_kbsr) begin
      rd_value[15] = kb_ready;
      rd_value[14] = kb_overrun;
    end else if (is_kbdr) begin
      rd_value[7:0] = kb_char;
    end else if (is_dsr) begin
      rd_value[15] = !dd_valid;
    end
  end

  // Datapath registers and device state
  always_ff @(posedge clk) begin
    if (!reset) begin
      mar        <= '0;
      mdr        <= '0;
      rd_data    <= '0;
      acc_addr   <= '0;
      acc_we     <= 1'b0;
      kb_char    <= '0;
      kb_ready   <= 1'b0;
      kb_overrun <= 1'b0;
      dd_data    <= '0;
      dd_valid   <= 1'b0;
    end else begin
      if (ldMAR) begin
        mar <= Bus[ADDR_W-1:0];
      end

      if (state == ST_IDLE && mem_en) begin
        acc_addr <= mar;
        acc_we   <= memWE;
      end

      if (done_read) begin
        rd_data <= rd_value;
      end

      // In DONE the read result is not in rd_data yet, so forward it.
      if (ldMDR) begin
        if (!selMDR) begin
          mdr <= Bus;
        end else if (done_read) begin
          mdr <= rd_value;
        end else begin
          mdr <= rd_data;
        end
      end

      // A strobe coinciding with a KBDR read keeps the new character pending
      // while the overrun condition is considered consumed by the read.
      if (kb_valid) begin
        kb_char    <= kb_data;
        kb_ready   <= 1'b1;
        kb_overrun <= (done_read && is_kbdr) ? 1'b0 : (kb_overrun | kb_ready);
      end else if (done_read && is_kbdr) begin
        kb_ready   <= 1'b0;
        kb_overrun <= 1'b0;
      end

      // A new DDR write wins over a same-cycle handshake.
      if (done_write && is_ddr) begin
        dd_data  <= mdr[7:0];
        dd_valid <= 1'b1;
      end else if (dd_valid && dd_ready) begin
        dd_valid <= 1'b0;
      end
    end
  end

  // Backing RAM; not cleared by reset, and a reset in DONE blocks the write.
  always_ff @(posedge clk) begin
    if (reset && done_write && ram_hit) begin
      ram[ram_idx] <= mdr;
    end
  end

  assign R        = done;
  assign addr_err = done && !mapped;
  assign MDROut   = mdr;

endmodule

// File: doc/lc3_mem_ctrl.md
# lc3_mem_ctrl

Parametrised memory and memory-mapped I/O controller for the LC-3 datapath, replacing the fixed single-cycle memory with a MAR/MDR unit that has a ready handshake, configurable wait states and the standard keyboard/display device registers. Sits between the shared Bus and backing RAM: the FSM raises `mem_en`, waits for `R`, then gates `MDROut` onto the Bus as before. Width, RAM depth and access latency are parameters.

## Interface
- `WIDTH`, 16, data/Bus width (≥ 16)
- `ADDR_W`, 16, MAR width
- `DEPTH_LOG2`, 10, backing RAM holds 2^DEPTH_LOG2 words at addresses 0..2^DEPTH_LOG2−1
- `WAIT_STATES`, 2, extra cycles per access (0..15)
- `clk` in 1, single clock, all state on rising edge
- `reset` in 1, synchronous, active-low
- `Bus` in WIDTH, shared datapath bus
- `ldMAR` in 1, load MAR from Bus[ADDR_W-1:0]
- `ldMDR` in 1, load MDR (source per `selMDR`)
- `selMDR` in 1, 0 = Bus, 1 = completed read data
- `mem_en` in 1, start access at current MAR
- `memWE` in 1, access is write (sampled with `mem_en`)
- `R` out 1, access complete, one-cycle pulse
- `MDROut` out WIDTH, MDR contents
- `addr_err` out 1, one-cycle pulse: access to unmapped address
- `kb_data` in 8, keyboard character
- `kb_valid` in 1, keyboard character strobe
- `dd_data` out 8, display character
- `dd_valid` out 1, display character pending
- `dd_ready` in 1, display accepts character when high with `dd_valid`

## Operation
- Map: RAM below 2^DEPTH_LOG2; KBSR xFE00, KBDR xFE02, DSR xFE04, DDR xFE06 (low 16 bits, upper MAR bits zero); all else unmapped.
- FSM: IDLE → WAIT (count WAIT_STATES) → DONE → IDLE. WAIT skipped when WAIT_STATES=0. `mem_en`/`memWE`/MAR sampled only in IDLE; ignored in WAIT/DONE.
- DONE: `R`=1 for one cycle. Read: result latched into read-data register, loaded into MDR if `ldMDR && selMDR` that cycle or later (held until next access). Write: MDR written to target in DONE.
- `ldMDR && !selMDR`: MDR ← Bus, any state. `ldMAR` any state, takes effect for next access.
- KBSR read: bit15 = kb_ready, bit14 = kb_overrun, rest 0. KBDR read: {0, char}; clears kb_ready and kb_overrun.
- `kb_valid`: char ← kb_data, kb_ready ← 1; if kb_ready already 1, kb_overrun ← 1 (new char kept). Same cycle as KBDR-read DONE: new char wins, kb_ready stays 1, overrun cleared.
- DSR read: bit15 = !dd_valid. DDR write: dd_data ← MDR[7:0], dd_valid ← 1. `dd_valid && dd_ready`: dd_valid ← 0 next edge. DDR write while dd_valid: overwrites dd_data, dd_valid stays 1.
- Writes to KBSR/KBDR/DSR and reads of DDR: no effect / return 0.
- Unmapped: read returns 0, write dropped, `addr_err` pulses with `R`.

## Timing
- Reset (reset=0 at edge): FSM IDLE, MAR=0, MDR=0, read-data=0, `R`=0, `addr_err`=0, kb_ready=kb_overrun=0, `dd_valid`=0, `dd_data`=0. RAM contents not cleared.
- Latency: `mem_en` sampled at edge N → `R` high during cycle N+WAIT_STATES+1.
- Back-to-back: new `mem_en` accepted the cycle after DONE (IDLE), throughput one access per WAIT_STATES+2 cycles.
- Reset mid-access: access aborted, no RAM write, no `R`.
- `MDROut` and `dd_*` are registered; `R`, `addr_err` registered from FSM state.

## Test plan
- WAIT_STATES=2: write x1234 to x0005, read back → `R` 3 cycles after each `mem_en`, MDROut=x1234 after `ldMDR`,`selMDR`=1.
- Keyboard: `kb_valid` with x41 → KBSR=x8000, KBDR=x0041, then KBSR=x0000; two strobes before read → KBSR=xC000, KBDR holds second char.
- Display: write x0048 to xFE06 → dd_valid=1, dd_data=x48, DSR=x0000; hold dd_ready=0 then 1 → dd_valid drops next edge, DSR=x8000.
- Unmapped read xF000 (DEPTH_LOG2=10) → MDR=0, `addr_err` coincident with `R`; write there leaves RAM unchanged.
- reset low during WAIT of write to x0010 → no `R`, x0010 retains prior value, all outputs at reset values.
- WAIT_STATES=0: `R` one cycle after `mem_en`; `mem_en` held in DONE not re-accepted until IDLE.
